linear_layer_srl_fifo_af: RTL and testbench



---
 rtl/linear_layer_srl_fifo_af.sv | 90 +++++++++
 tb/tb_linear_layer_srl_fifo_af.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_srl_fifo_af.sv
// Shift-register FIFO with registered count/flags, almost-full warning and sticky error flags.
// Data is visible 1 cycle after the write; writes are dropped while full and reads ignored while empty.
module linear_layer_srl_fifo_af #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int AF_LEVEL   = 28
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   output logic                  if_almost_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

   logic [DATA_WIDTH-1:0] srl [DEPTH];
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_req;
   logic                  rd_req;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_req = if_write & if_write_ce;
   assign rd_req = if_read & if_read_ce;
   assign wr_acc = wr_req & if_full_n;
   assign rd_acc = rd_req & if_empty_n;

   // Newest entry sits at srl[0]; addr points at the oldest one.
   assign if_dout = srl[addr];

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = DEPTH-1; i > 0; i--) begin
            srl[i] <= srl[i-1];
         end
         srl[0] <= if_din;
      end
   end

   always_comb begin
      count_next = count;
      addr_next  = addr;
      case ({wr_acc, rd_acc})
         2'b10: begin
            count_next = count + 1'b1;
            if (count != '0) addr_next = addr + 1'b1;
         end
         2'b01: begin
            count_next = count - 1'b1;
            if (count != (ADDR_WIDTH+1)'(1)) addr_next = addr - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count            <= '0;
         addr             <= '0;
         if_full_n        <= 1'b1;
         if_almost_full_n <= 1'b1;
         if_empty_n       <= 1'b0;
         overflow         <= 1'b0;
         underflow        <= 1'b0;
      end else begin
         count            <= count_next;
         addr             <= addr_next;
         if_full_n        <= (count_next != DEPTH_C);
         if_empty_n       <= (count_next != '0);
         if_almost_full_n <= (count_next < AF_C);
         if (wr_req && !if_full_n) overflow <= 1'b1;
         if (rd_req && !if_empty_n) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_linear_layer_srl_fifo_af.sv
// Directed bench for linear_layer_srl_fifo_af at DEPTH=32, AF_LEVEL=28.
module tb_linear_layer_srl_fifo_af;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_write_ce;
   logic        if_write;
   logic [31:0] if_din;
   logic        if_full_n;
   logic        if_almost_full_n;
   logic        if_read_ce;
   logic        if_read;
   logic [31:0] if_dout;
   logic        if_empty_n;
   logic [5:0]  count;
   logic        overflow;
   logic        underflow;

   int tests = 0;
   int fails = 0;

   linear_layer_srl_fifo_af #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .AF_LEVEL(28)
   ) dut (
      .clk(clk), .reset(reset),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
      .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n),
      .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
      .if_empty_n(if_empty_n), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; if_write_ce = 1'b1; if_write = 1'b0; if_din = '0;
      if_read_ce = 1'b1; if_read = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

      check("rst_count", 64'(count), 64'd0);
      check("rst_empty_n", 64'(if_empty_n), 64'd0);
      check("rst_full_n", 64'(if_full_n), 64'd1);
      check("rst_af_n", 64'(if_almost_full_n), 64'd1);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_underflow", 64'(underflow), 64'd0);

      // Fill 0..31 back to back.
      if_write = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if_din = 32'(i);
         step();
         if (i == 0)  check("fill_head", 64'(if_dout), 64'd0);
         if (i == 26) check("fill_af_n_27", 64'(if_almost_full_n), 64'd1);
         if (i == 27) check("fill_af_n_28", 64'(if_almost_full_n), 64'd0);
         if (i == 30) check("fill_full_n_31", 64'(if_full_n), 64'd1);
      end
      if_write = 1'b0;
      check("fill_full_n_32", 64'(if_full_n), 64'd0);
      check("fill_count", 64'(count), 64'd32);

      if_read = 1'b1;
      for (int i = 0; i < 32; i++) begin
         check("drain_dout", 64'(if_dout), 64'(i));
         step();
      end
      if_read = 1'b0;
      check("drain_empty_n", 64'(if_empty_n), 64'd0);
      check("drain_count", 64'(count), 64'd0);
      check("drain_underflow", 64'(underflow), 64'd0);

      // Single write then read.
      if_din = 32'hA5; if_write = 1'b1;
      step();
      if_write = 1'b0;
      check("single_empty_n", 64'(if_empty_n), 64'd1);
      check("single_dout", 64'(if_dout), 64'hA5);
      check("single_count1", 64'(count), 64'd1);
      if_read = 1'b1;
      step();
      if_read = 1'b0;
      check("single_count0", 64'(count), 64'd0);
      check("single_empty_n0", 64'(if_empty_n), 64'd0);

      // Sustained read+write at count 1.
      if_din = 32'd1000; if_write = 1'b1;
      step();
      if_read = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if_din = 32'(1001 + k);
         check("stream_dout", 64'(if_dout), 64'(1000 + k));
         step();
         check("stream_count", 64'(count), 64'd1);
      end
      if_write = 1'b0;
      check("stream_tail", 64'(if_dout), 64'd1100);
      step();
      if_read = 1'b0;
      check("stream_drained", 64'(count), 64'd0);

      // Read+write while full: write dropped, read accepted.
      if_write = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if_din = 32'h100 + 32'(i);
         step();
      end
      check("full2_full_n", 64'(if_full_n), 64'd0);
      if_din = 32'hDEAD; if_read = 1'b1;
      check("full2_oldest", 64'(if_dout), 64'h100);
      step();
      if_write = 1'b0; if_read = 1'b0;
      check("full2_count", 64'(count), 64'd31);
      check("full2_overflow", 64'(overflow), 64'd1);
      check("full2_full_n_after", 64'(if_full_n), 64'd1);
      if_read = 1'b1;
      for (int i = 0; i < 31; i++) begin
         check("full2_drain", 64'(if_dout), 64'(32'h101 + 32'(i)));
         step();
      end
      check("full2_empty_n", 64'(if_empty_n), 64'd0);
      check("full2_underflow_pre", 64'(underflow), 64'd0);
      step();
      if_read = 1'b0;
      check("underflow_set", 64'(underflow), 64'd1);
      check("underflow_count", 64'(count), 64'd0);
      check("overflow_sticky", 64'(overflow), 64'd1);

      // Reset mid-operation with a concurrent write.
      if_write = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if_din = 32'h200 + 32'(i);
         step();
      end
      check("pre_rst_count", 64'(count), 64'd10);
      if_din = 32'h999; reset = 1'b1;
      step();
      reset = 1'b0; if_write = 1'b0;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_empty_n", 64'(if_empty_n), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      check("mid_rst_underflow", 64'(underflow), 64'd0);
      if_din = 32'h55; if_write = 1'b1;
      step();
      check("post_rst_count", 64'(count), 64'd1);
      check("post_rst_dout", 64'(if_dout), 64'h55);
      if_write_ce = 1'b0; if_din = 32'h77;
      step();
      check("ce_off_count", 64'(count), 64'd1);
      check("ce_off_dout", 64'(if_dout), 64'h55);
      if_write = 1'b0; if_write_ce = 1'b1;

      // Pop, then read+write while empty: read rejected, write accepted.
      if_read = 1'b1;
      step();
      check("pop55_count", 64'(count), 64'd0);
      if_read_ce = 1'b0;
      step();
      check("read_ce_off_underflow", 64'(underflow), 64'd0);
      if_read_ce = 1'b1; if_write = 1'b1; if_din = 32'h66;
      step();
      if_read = 1'b0; if_write = 1'b0;
      check("empty_rw_count", 64'(count), 64'd1);
      check("empty_rw_underflow", 64'(underflow), 64'd1);
      check("empty_rw_dout", 64'(if_dout), 64'h66);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
